// File: rtl/move_walker_pkg.sv
// move_walker_pkg: shared definitions for the root-move walker.
//   - RES_* result codes reported on move_walker.status
//   - MOVE_WALKER_TIMEOUT_CYCLES: EVAL_WAIT cycle limit, used only when
//     MOVE_WALKER_TIMEOUT_EN is defined.
package move_walker_pkg;

    typedef logic [1:0] res_t;

    localparam res_t RES_OK      = 2'd0;
    localparam res_t RES_MATE    = 2'd1;
    localparam res_t RES_STALE   = 2'd2;
    localparam res_t RES_TIMEOUT = 2'd3;

    localparam int MOVE_WALKER_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/move_walker_eval_better.sv
// eval_better: combinational comparator for the root-move search.
// Ports:
//   white_to_move  in  1 = maximizing side, 0 = minimizing side
//   candidate      in  signed evaluation of the move just scored
//   incumbent      in  signed evaluation of the best move so far
//   better         out 1 when candidate is strictly better for the side
//                      to move (ties report 0 so the lower index is kept)
module eval_better #(
    parameter int EVAL_WIDTH = 22
) (
    input  logic                         white_to_move,
    input  logic signed [EVAL_WIDTH-1:0] candidate,
    input  logic signed [EVAL_WIDTH-1:0] incumbent,
    output logic                         better
);

    // Strict comparison in the direction favoured by the side to move
    always_comb begin
        if (white_to_move) begin
            better = (candidate > incumbent);
        end else begin
            better = (candidate < incumbent);
        end
    end

endmodule

// File: rtl/move_walker.sv
// move_walker: walks the move list produced by all_moves, runs evaluate on
// each position, keeps the best score for the root side to move, reports it
// and re-arms the generator with clear_moves.
// Optional feature macro: MOVE_WALKER_TIMEOUT_EN (EVAL_WAIT watchdog that
// ends the walk with RES_TIMEOUT if evaluate never answers).
// Ports:
//   clk, reset (async, active low)
//   moves_ready, move_count, mate, stalemate   <- all_moves
//   white_to_move                              <- root side to move
//   eval, eval_valid                           <- evaluate
//   move_index                                 -> move RAM read address
//   eval_start, clear_eval                     -> evaluate (1-cycle pulses)
//   clear_moves                                -> all_moves (1-cycle pulse)
//   busy, result_valid, best_index, best_eval, status -> result
// All outputs come straight from flops.
module move_walker
    import move_walker_pkg::*;
#(
    parameter int MAX_POSITIONS      = 64,
    parameter int MAX_POSITIONS_LOG2 = $clog2(MAX_POSITIONS),
    parameter int EVAL_WIDTH         = 22
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          moves_ready,
    input  logic [MAX_POSITIONS_LOG2-1:0] move_count,
    input  logic                          mate,
    input  logic                          stalemate,
    input  logic                          white_to_move,
    input  logic signed [EVAL_WIDTH-1:0]  eval,
    input  logic                          eval_valid,
    output logic [MAX_POSITIONS_LOG2-1:0] move_index,
    output logic                          eval_start,
    output logic                          clear_eval,
    output logic                          clear_moves,
    output logic                          busy,
    output logic                          result_valid,
    output logic [MAX_POSITIONS_LOG2-1:0] best_index,
    output logic signed [EVAL_WIDTH-1:0]  best_eval,
    output logic [1:0]                    status
);

    localparam int IW = MAX_POSITIONS_LOG2;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RAM_WAIT   = 3'd1,
        S_EVAL_START = 3'd2,
        S_EVAL_WAIT  = 3'd3,
        S_DONE       = 3'd4,
        S_CLEAR_WAIT = 3'd5
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           move_index_q, move_index_d;
    logic [IW-1:0]           count_q, count_d;
    logic                    wtm_q, wtm_d;
    logic [IW-1:0]           best_index_q, best_index_d;
    logic signed [EVAL_WIDTH-1:0] best_eval_q, best_eval_d;
    res_t                    status_q, status_d;
    logic                    eval_start_q, eval_start_d;
    logic                    clear_eval_q, clear_eval_d;
    logic                    clear_moves_q, clear_moves_d;
    logic                    busy_q, busy_d;
    logic                    result_valid_q, result_valid_d;
    logic                    cand_better_s;
    // One extra bit so the last index of a full-width list cannot wrap to 0
    logic [IW:0]             idx_next_s;
`ifdef MOVE_WALKER_TIMEOUT_EN
    localparam logic [7:0] TMO_LAST = 8'(MOVE_WALKER_TIMEOUT_CYCLES - 1);
    logic [7:0]              tmo_cnt_q, tmo_cnt_d;
`endif

    eval_better #(
        .EVAL_WIDTH (EVAL_WIDTH)
    ) u_eval_better (
        .white_to_move (wtm_q),
        .candidate     (eval),
        .incumbent     (best_eval_q),
        .better        (cand_better_s)
    );

    assign idx_next_s = {1'b0, move_index_q} + {{IW{1'b0}}, 1'b1};

    // Next-state, datapath update and next-cycle output pulses
    always_comb begin
        state_d        = state_q;
        move_index_d   = move_index_q;
        count_d        = count_q;
        wtm_d          = wtm_q;
        best_index_d   = best_index_q;
        best_eval_d    = best_eval_q;
        status_d       = status_q;
        busy_d         = busy_q;
        eval_start_d   = 1'b0;
        clear_eval_d   = 1'b0;
        clear_moves_d  = 1'b0;
        result_valid_d = 1'b0;
`ifdef MOVE_WALKER_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (moves_ready) begin
                    move_index_d = {IW{1'b0}};
                    count_d      = move_count;
                    wtm_d        = white_to_move;
                    best_index_d = {IW{1'b0}};
                    best_eval_d  = {EVAL_WIDTH{1'b0}};
                    busy_d       = 1'b1;
                    if (move_count == {IW{1'b0}}) begin
                        state_d        = S_DONE;
                        result_valid_d = 1'b1;
                        clear_moves_d  = 1'b1;
                        // An empty list that is not mate is always a draw,
                        // whether or not the generator raised stalemate.
                        if (mate) begin
                            status_d = RES_MATE;
                        end else if (stalemate) begin
                            status_d = RES_STALE;
                        end else begin
                            status_d = RES_STALE;
                        end
                    end else begin
                        state_d = S_RAM_WAIT;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_RAM_WAIT: begin
                state_d      = S_EVAL_START;
                eval_start_d = 1'b1;
            end
            S_EVAL_START: begin
                state_d = S_EVAL_WAIT;
`ifdef MOVE_WALKER_TIMEOUT_EN
                tmo_cnt_d = 8'd0;
`endif
            end
            S_EVAL_WAIT: begin
                if (eval_valid) begin
                    clear_eval_d = 1'b1;
                    if ((move_index_q == {IW{1'b0}}) || cand_better_s) begin
                        best_index_d = move_index_q;
                        best_eval_d  = eval;
                    end else begin
                        best_index_d = best_index_q;
                    end
                    if (idx_next_s < {1'b0, count_q}) begin
                        move_index_d = idx_next_s[IW-1:0];
                        state_d      = S_RAM_WAIT;
                    end else begin
                        state_d        = S_DONE;
                        status_d       = RES_OK;
                        result_valid_d = 1'b1;
                        clear_moves_d  = 1'b1;
                    end
`ifdef MOVE_WALKER_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d        = S_DONE;
                    status_d       = RES_TIMEOUT;
                    result_valid_d = 1'b1;
                    clear_moves_d  = 1'b1;
                    clear_eval_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
`else
                end else begin
                    state_d = S_EVAL_WAIT;
                end
`endif
            end
            S_DONE: begin
                state_d = S_CLEAR_WAIT;
            end
            S_CLEAR_WAIT: begin
                // Hold until the generator drops its stale moves_ready
                if (!moves_ready) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_CLEAR_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            move_index_q   <= {IW{1'b0}};
            count_q        <= {IW{1'b0}};
            wtm_q          <= 1'b0;
            best_index_q   <= {IW{1'b0}};
            best_eval_q    <= {EVAL_WIDTH{1'b0}};
            status_q       <= RES_OK;
            busy_q         <= 1'b0;
            eval_start_q   <= 1'b0;
            clear_eval_q   <= 1'b0;
            clear_moves_q  <= 1'b0;
            result_valid_q <= 1'b0;
`ifdef MOVE_WALKER_TIMEOUT_EN
            tmo_cnt_q      <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            move_index_q   <= move_index_d;
            count_q        <= count_d;
            wtm_q          <= wtm_d;
            best_index_q   <= best_index_d;
            best_eval_q    <= best_eval_d;
            status_q       <= status_d;
            busy_q         <= busy_d;
            eval_start_q   <= eval_start_d;
            clear_eval_q   <= clear_eval_d;
            clear_moves_q  <= clear_moves_d;
            result_valid_q <= result_valid_d;
`ifdef MOVE_WALKER_TIMEOUT_EN
            tmo_cnt_q      <= tmo_cnt_d;
`endif
        end
    end

    assign move_index   = move_index_q;
    assign eval_start   = eval_start_q;
    assign clear_eval   = clear_eval_q;
    assign clear_moves  = clear_moves_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign best_index   = best_index_q;
    assign best_eval    = best_eval_q;
    assign status       = status_q;

endmodule

// File: tb/tb_move_walker.sv
// tb_move_walker: directed scoreboard bench for move_walker.
// Stimulus pushes the expected result of each walk into a queue; a monitor
// pops and compares whenever result_valid is seen. A behavioural evaluate
// model answers each eval_start after a programmable latency with the score
// held in a per-index table.
module tb_move_walker;

    localparam int LOG2 = 6;
    localparam int EW   = 22;

    logic                 clk;
    logic                 reset;
    logic                 moves_ready;
    logic [LOG2-1:0]      move_count;
    logic                 mate;
    logic                 stalemate;
    logic                 white_to_move;
    logic signed [EW-1:0] eval;
    logic                 eval_valid;
    logic [LOG2-1:0]      move_index;
    logic                 eval_start;
    logic                 clear_eval;
    logic                 clear_moves;
    logic                 busy;
    logic                 result_valid;
    logic [LOG2-1:0]      best_index;
    logic signed [EW-1:0] best_eval;
    logic [1:0]           status;

    move_walker #(
        .MAX_POSITIONS      (64),
        .MAX_POSITIONS_LOG2 (LOG2),
        .EVAL_WIDTH         (EW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .moves_ready   (moves_ready),
        .move_count    (move_count),
        .mate          (mate),
        .stalemate     (stalemate),
        .white_to_move (white_to_move),
        .eval          (eval),
        .eval_valid    (eval_valid),
        .move_index    (move_index),
        .eval_start    (eval_start),
        .clear_eval    (clear_eval),
        .clear_moves   (clear_moves),
        .busy          (busy),
        .result_valid  (result_valid),
        .best_index    (best_index),
        .best_eval     (best_eval),
        .status        (status)
    );

    typedef struct {
        int idx;
        int ev;
        int st;
        int starts;
        int max_idx;
    } exp_t;

    exp_t q[$];
    int   checks       = 0;
    int   errors       = 0;
    int   results_seen = 0;
    int   start_cnt    = 0;
    int   max_idx      = -1;
    int   evals[64];
    int   lat          = 1;
    bit   eval_en      = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural evaluate: answers an eval_start after lat cycles
    initial begin
        eval       = '0;
        eval_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (eval_start) begin
                int idx;
                idx = int'(move_index);
                repeat (lat) @(posedge clk);
                #1;
                if (eval_en) begin
                    eval       = EW'(evals[idx]);
                    eval_valid = 1'b1;
                    @(posedge clk);
                    #1;
                    eval_valid = 1'b0;
                end
            end
        end
    end

    // Monitor: scoreboard compare on every result_valid
    initial begin
        forever begin
            @(negedge clk);
            if (eval_start || clear_eval) begin
                check("start_clear_overlap", int'(eval_start && clear_eval), 0);
            end
            if (!reset) begin
                start_cnt = 0;
                max_idx   = -1;
            end else if (result_valid) begin
                if (q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("best_index",  int'(best_index), e.idx);
                    check("best_eval",   int'(best_eval),  e.ev);
                    check("status",      int'(status),     e.st);
                    check("eval_starts", start_cnt,        e.starts);
                    check("max_index",   max_idx,          e.max_idx);
                    check("clear_moves", int'(clear_moves), 1);
                    check("clear_eval_at_done", int'(clear_eval), int'(e.starts > 0));
                    check("busy_at_done", int'(busy), 1);
                end
                results_seen++;
                start_cnt = 0;
                max_idx   = -1;
            end else if (eval_start) begin
                start_cnt++;
                if (int'(move_index) > max_idx) max_idx = int'(move_index);
            end
        end
    end

    task automatic run_walk(input int cnt, input bit wtm, input bit m, input bit s,
                            input int e_idx, input int e_ev, input int e_st,
                            input int e_starts);
        exp_t e;
        int   seen0;
        e.idx     = e_idx;
        e.ev      = e_ev;
        e.st      = e_st;
        e.starts  = e_starts;
        e.max_idx = e_starts - 1;
        q.push_back(e);
        seen0 = results_seen;
        @(posedge clk);
        #1;
        move_count    = LOG2'(cnt);
        white_to_move = wtm;
        mate          = m;
        stalemate     = s;
        moves_ready   = 1'b1;
        if (cnt > 0) begin
            @(negedge clk);
            check("start_lat_c0", int'(eval_start), 0);
            @(posedge clk);
            #1;
            // Inputs change after accept; the walker must use its copies
            move_count    = '0;
            white_to_move = ~wtm;
            @(negedge clk);
            check("start_lat_c1", int'(eval_start), 0);
            @(negedge clk);
            check("start_lat_c2", int'(eval_start), 1);
        end
        for (int i = 0; i < 3000 && results_seen == seen0; i++) @(posedge clk);
        if (results_seen == seen0) check("walk_complete", 0, 1);
        // Stale moves_ready held high: must not be re-accepted
        repeat (4) @(posedge clk);
        #1;
        check("busy_stale_ready", int'(busy), 1);
        moves_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("busy_idle", int'(busy), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   int'(busy), 0);
        check({tag, "_index"},  int'(move_index), 0);
        check({tag, "_pulses"}, int'({eval_start, clear_eval, clear_moves, result_valid}), 0);
        check({tag, "_best"},   int'(best_index) + int'(best_eval), 0);
        check({tag, "_status"}, int'(status), 0);
    endtask

    initial begin
        reset         = 1'b0;
        moves_ready   = 1'b0;
        move_count    = '0;
        mate          = 1'b0;
        stalemate     = 1'b0;
        white_to_move = 1'b0;
        for (int i = 0; i < 64; i++) evals[i] = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // White maximizes, tie at 50 keeps index 1
        evals[0] = 10; evals[1] = 50; evals[2] = 50;
        run_walk(3, 1'b1, 1'b0, 1'b0, 1, 50, 0, 3);

        // Black minimizes
        evals[0] = -5; evals[1] = -30; evals[2] = 20;
        run_walk(3, 1'b0, 1'b0, 1'b0, 1, -30, 0, 3);

        // No legal moves: mate, then stalemate
        run_walk(0, 1'b1, 1'b1, 1'b0, 0, 0, 1, 0);
        run_walk(0, 1'b0, 1'b0, 1'b1, 0, 0, 2, 0);

        // Black, ties with longer evaluate latency: lower index kept
        lat = 3;
        evals[0] = 7; evals[1] = 7; evals[2] = 3; evals[3] = 3;
        run_walk(4, 1'b0, 1'b0, 1'b0, 2, 3, 0, 4);

        // White, all negative, winner in the middle
        lat = 2;
        evals[0] = -100; evals[1] = -20; evals[2] = -20; evals[3] = -400;
        run_walk(4, 1'b1, 1'b0, 1'b0, 1, -20, 0, 4);

        // Single move is always chosen
        lat = 1;
        evals[0] = -7;
        run_walk(1, 1'b1, 1'b0, 1'b0, 0, -7, 0, 1);

        // Full-width list, ascending evals: last index wins, no wrap
        for (int i = 0; i < 63; i++) evals[i] = i * 3 - 50;
        run_walk(63, 1'b1, 1'b0, 1'b0, 62, 136, 0, 63);

        // Reset during EVAL_WAIT, then re-accept and walk from index 0
        evals[0] = 5; evals[1] = 9;
        eval_en = 1'b0;
        @(posedge clk);
        #1;
        move_count    = LOG2'(2);
        white_to_move = 1'b1;
        moves_ready   = 1'b1;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("midreset");
        begin
            exp_t e;
            int   seen0;
            e.idx = 1; e.ev = 9; e.st = 0; e.starts = 2; e.max_idx = 1;
            q.push_back(e);
            seen0   = results_seen;
            eval_en = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b1;
            for (int i = 0; i < 3000 && results_seen == seen0; i++) @(posedge clk);
            if (results_seen == seen0) check("rewalk_complete", 0, 1);
            @(posedge clk);
            #1;
            moves_ready = 1'b0;
            repeat (3) @(posedge clk);
        end

`ifdef MOVE_WALKER_TIMEOUT_EN
        // evaluate never answers: timeout with best cleared at accept
        eval_en = 1'b0;
        run_walk(2, 1'b1, 1'b0, 1'b0, 0, 0, 3, 1);
        eval_en = 1'b1;
`endif

        check("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
